axis_pkt_arbiter_2to1: RTL and testbench
========================================

# axis_pkt_arbiter_2to1

Packet-granular round-robin arbiter that shares one downstream AXI4-Stream master port between two upstream AXI4-Stream slave ports. It sits in front of the stream-processing IP in the HFT datapath and merges two feed sources into its single 32-bit sink without interleaving beats of different packets. Arbitration switches only on `tlast` boundaries. A 2-entry output skid FIFO sustains one beat per cycle under steady flow and absorbs backpressure.

## Interface
- `C_AXIS_TDATA_WIDTH`, 32: data width of all stream ports; `tstrb` width is `C_AXIS_TDATA_WIDTH/8`.
- `C_CNT_WIDTH`, 16: width of the per-input packet counters.
- `s00_axis_aclk` in, 1: single clock for all ports.
- `s00_axis_aresetn` in, 1: reset, asynchronous, active-low, shared by all ports.
- `s00_axis_tdata` in, `C_AXIS_TDATA_WIDTH`: input 0 data.
- `s00_axis_tstrb` in, `C_AXIS_TDATA_WIDTH/8`: input 0 byte strobes.
- `s00_axis_tlast` in, 1: input 0 end of packet.
- `s00_axis_tvalid` in, 1: input 0 valid.
- `s00_axis_tready` out, 1: input 0 ready.
- `s01_axis_tdata`, `s01_axis_tstrb`, `s01_axis_tlast`, `s01_axis_tvalid` (in) and `s01_axis_tready` (out): same as s00, for input 1.
- `m00_axis_tdata` out, `C_AXIS_TDATA_WIDTH`: output data.
- `m00_axis_tstrb` out, `C_AXIS_TDATA_WIDTH/8`: output strobes.
- `m00_axis_tlast` out, 1: output end of packet.
- `m00_axis_tvalid` out, 1: output valid.
- `m00_axis_tready` in, 1: output ready.
- `grant` out, 2: one-hot current owner; 00 when no port is granted.
- `pkt_cnt_s00` out, `C_CNT_WIDTH`: packets completed from input 0.
- `pkt_cnt_s01` out, `C_CNT_WIDTH`: packets completed from input 1.

## Operation
- FSM states:
  - ARB (reset state).
  - GRANT0.
  - GRANT1.
- ARB transitions:
  - Only one `tvalid` is high: go to the matching GRANTx on the next edge.
  - Both `tvalid` are high: grant the input that is not `last_grant`.
  - Neither is high: stay in ARB.
- `last_grant` updates on entry to a GRANT state. Reset value is 1, so input 0 wins the first tie.
- GRANTx:
  - `sxx_axis_tready = !fifo_full`. The non-granted `tready` is 0.
  - An accepted beat (`tvalid && tready`) pushes `{tdata, tstrb, tlast}` into the FIFO.
  - An accepted beat with `tlast=1` returns the FSM to ARB and increments `pkt_cnt_sxx`.
- Output FIFO: 2 entries. The head drives `m00_axis_*`, with `m00_axis_tvalid = !fifo_empty`. The head pops on `m00_axis_tvalid && m00_axis_tready`.
- Simultaneous push and pop in one cycle: occupancy is unchanged. `fifo_full` means occupancy is 2 and is computed from registered occupancy, so `tready` never depends on `m00_axis_tready` combinationally.
- Strobes are passed through unmodified. Packet content is never altered, dropped or reordered.
- Counters wrap modulo 2^`C_CNT_WIDTH` with no saturation.
- `grant` reflects the FSM state: 01 in GRANT0, 10 in GRANT1, 00 in ARB.
- Asynchronous reset, including mid-packet:
  - FSM returns to ARB and the FIFO is emptied, discarding any partial packet.
  - Counters clear and `last_grant` returns to 1.
  - The downstream side sees `tvalid` drop immediately.

## Timing
- Reset values: all `tready` 0, `m00_axis_tvalid` 0, `m00_axis_tdata`/`tstrb`/`tlast` 0, `grant` 00, counters 0.
- Arbitration latency: `tvalid` seen in ARB at edge N, grant and `tready` asserted from N+1.
- Data latency: a beat accepted at edge N is visible on `m00_axis_*` after edge N, i.e. valid in cycle N+1.
- Throughput:
  - Within a packet: 1 beat/cycle while `m00_axis_tready` is held high.
  - Between packets: one ARB bubble cycle on the input side.
- Backpressure: with `m00_axis_tready` low, at most 2 beats are accepted, then `tready` drops. It reasserts the cycle after the first pop.
- `tvalid` deassertion by the granted source mid-packet holds the grant; there is no timeout.

## Test plan
- Single packet:
  - Stimulus: s00 sends 4 beats (data 0,1,2,3, `tlast` on beat 3); `m00_axis_tready`=1; s01 idle.
  - Required: `m00` shows 0..3 on consecutive cycles, `tlast` on 3, first beat one cycle after accept; `pkt_cnt_s00`=1; `grant` 01 then 00.
- Simultaneous request out of reset:
  - Stimulus: s00 packet {0..3} and s01 packet {100..103} both valid from cycle 1.
  - Required: output is 0..3 then 100..103, never interleaved; `grant` 01, 00, 10.
- Fairness:
  - Stimulus: both inputs continuously offer 4-beat packets, 8 packets total.
  - Required: outputs alternate s00, s01, s00, ...; both counters end at 4.
- Backpressure:
  - Stimulus: s00 sends 8 beats; `m00_axis_tready` held low for 6 cycles mid-stream.
  - Required: exactly 2 beats are buffered, then `s00_axis_tready`=0; all 8 beats emerge in order with no duplication.
- Reset mid-packet:
  - Stimulus: `s00_axis_aresetn` low after beat 1 of a 4-beat packet.
  - Required: `m00_axis_tvalid` drops immediately, counters are 0, `grant` 00; a fresh packet after release passes intact.
- Counter wrap:
  - Stimulus: `C_CNT_WIDTH`=4; 17 one-beat packets on s01.
  - Required: `pkt_cnt_s01` reads 1 (wrapped through 0).

Source files
------------

// File: rtl/axis_pkt_arbiter_2to1.sv
// Two-input AXI4-Stream arbiter: packet-granular round robin switching on
// tlast, feeding a 2-entry output skid FIFO with per-input packet counters.
`timescale 1ns/1ps
module axis_pkt_arbiter_2to1 #(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_CNT_WIDTH        = 16
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]     s01_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s01_axis_tstrb,
    input  logic                              s01_axis_tlast,
    input  logic                              s01_axis_tvalid,
    output logic                              s01_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                              m00_axis_tlast,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic [1:0]                        grant,
    output logic [C_CNT_WIDTH-1:0]            pkt_cnt_s00,
    output logic [C_CNT_WIDTH-1:0]            pkt_cnt_s01
);

    localparam int SW = C_AXIS_TDATA_WIDTH / 8;

    typedef struct packed {
        logic [C_AXIS_TDATA_WIDTH-1:0] data;
        logic [SW-1:0]                 strb;
        logic                          last;
    } beat_t;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    logic clk;
    logic rst_n;

    assign clk   = s00_axis_aclk;
    assign rst_n = s00_axis_aresetn;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;

    logic [1:0] occ_q, occ_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    beat_t      mem0_q, mem1_q;
    beat_t      head;
    beat_t      in_beat;

    logic [C_CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [C_CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    logic fifo_full;
    logic fifo_empty;
    logic push0;
    logic push1;
    logic push;
    logic pop;
    logic req0;
    logic req1;

    assign req0 = s00_axis_tvalid;
    assign req1 = s01_axis_tvalid;

    // Full/empty come from registered occupancy only, so upstream tready
    // never has a combinational path from m00_axis_tready.
    assign fifo_full  = (occ_q == 2'd2);
    assign fifo_empty = (occ_q == 2'd0);

    assign push0 = s00_axis_tvalid && s00_axis_tready;
    assign push1 = s01_axis_tvalid && s01_axis_tready;
    assign push  = push0 || push1;
    assign pop   = !fifo_empty && m00_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ARB: begin
                unique case (1'b1)
                    req0 && req1: begin
                        state_d = last_grant_q ? GRANT0 : GRANT1;
                    end
                    req0 && !req1: state_d = GRANT0;
                    !req0 && req1: state_d = GRANT1;
                    default:       state_d = ARB;
                endcase
                if (state_d == GRANT0) begin
                    last_grant_d = 1'b0;
                end else if (state_d == GRANT1) begin
                    last_grant_d = 1'b1;
                end
            end
            GRANT0: begin
                if (push0 && s00_axis_tlast) begin
                    state_d = ARB;
                end
            end
            GRANT1: begin
                if (push1 && s01_axis_tlast) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        grant           = 2'b00;
        s00_axis_tready = 1'b0;
        s01_axis_tready = 1'b0;
        unique case (state_q)
            GRANT0: begin
                grant           = 2'b01;
                s00_axis_tready = !fifo_full;
            end
            GRANT1: begin
                grant           = 2'b10;
                s01_axis_tready = !fifo_full;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    always_comb begin
        if (state_q == GRANT1) begin
            in_beat = '{data: s01_axis_tdata,
                        strb: s01_axis_tstrb,
                        last: s01_axis_tlast};
        end else begin
            in_beat = '{data: s00_axis_tdata,
                        strb: s00_axis_tstrb,
                        last: s00_axis_tlast};
        end
    end

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        if (push) begin
            wr_ptr_d = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem0_q   <= '0;
            mem1_q   <= '0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push && !wr_ptr_q) begin
                mem0_q <= in_beat;
            end
            if (push && wr_ptr_q) begin
                mem1_q <= in_beat;
            end
        end
    end

    assign head            = rd_ptr_q ? mem1_q : mem0_q;
    assign m00_axis_tdata  = head.data;
    assign m00_axis_tstrb  = head.strb;
    assign m00_axis_tlast  = head.last;
    assign m00_axis_tvalid = !fifo_empty;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (push0 && s00_axis_tlast) begin
            cnt0_d = cnt0_q + C_CNT_WIDTH'(1);
        end
        if (push1 && s01_axis_tlast) begin
            cnt1_d = cnt1_q + C_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign pkt_cnt_s00 = cnt0_q;
    assign pkt_cnt_s01 = cnt1_q;

endmodule

// File: tb/tb_axis_pkt_arbiter_2to1.sv
// Bench for axis_pkt_arbiter_2to1: vector table, directed packet sequences
// and randomized traffic against a packet-level reference model.
`timescale 1ns/1ps
module tb_axis_pkt_arbiter_2to1;

    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    typedef struct {
        logic          v0;
        logic [DW-1:0] d0;
        logic          l0;
        logic          mr;
        logic [1:0]    g;
        logic          r0;
        logic          r1;
        logic          mv;
        logic [DW-1:0] md;
        logic          ml;
        logic [CW-1:0] c0;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic          sv [2];
    logic [DW-1:0] sd [2];
    logic [SW-1:0] ss [2];
    logic          sl [2];
    logic          s_r [2];
    logic [DW-1:0] m_d;
    logic [SW-1:0] m_s;
    logic          m_l;
    logic          m_v;
    logic          m_r;
    logic [1:0]    grant;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    axis_pkt_arbiter_2to1 #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_CNT_WIDTH(CW)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tdata(sd[0]),
        .s00_axis_tstrb(ss[0]),
        .s00_axis_tlast(sl[0]),
        .s00_axis_tvalid(sv[0]),
        .s00_axis_tready(s_r[0]),
        .s01_axis_tdata(sd[1]),
        .s01_axis_tstrb(ss[1]),
        .s01_axis_tlast(sl[1]),
        .s01_axis_tvalid(sv[1]),
        .s01_axis_tready(s_r[1]),
        .m00_axis_tdata(m_d),
        .m00_axis_tstrb(m_s),
        .m00_axis_tlast(m_l),
        .m00_axis_tvalid(m_v),
        .m00_axis_tready(m_r),
        .grant(grant),
        .pkt_cnt_s00(cnt0),
        .pkt_cnt_s01(cnt1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-source packet queues, order of grants,
    // number of beats held downstream and who owns the input side.
    beat_t         tx_q [2][$];
    beat_t         exp_q [2][$];
    int            gorder [$];
    int            glog [$];
    int            owner;
    int            occ;
    int            lastg;
    int            out_src;
    int            beats_out;
    logic [CW-1:0] mc [2];
    logic          hs [2];
    bit            gap_en;
    int            rdy_mode;
    int            cyc;
    int            lo_start;
    int            lo_len;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic fail(string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event expected none at %0t", nm, $time);
    endtask

    task automatic add_pkt(int src, int n, int base, bit rnd);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = rnd ? DW'($urandom) : DW'(base + i);
            b.s = rnd ? SW'($urandom) : {SW{1'b1}};
            b.l = (i == n - 1);
            tx_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
    endtask

    function automatic logic [15:0] log_code();
        logic [7:0] b;
        b = 8'd0;
        foreach (glog[i]) b = {b[6:0], (glog[i] == 1)};
        return {8'(glog.size()), b};
    endfunction

    // Called just after a rising edge: advance sources and the sink.
    task automatic drive();
        for (int x = 0; x < 2; x++) begin
            if (hs[x]) begin
                void'(tx_q[x].pop_front());
                sv[x] = 1'b0;
            end
            if (tx_q[x].size() == 0) begin
                sv[x] = 1'b0;
            end else if (!sv[x]) begin
                sv[x] = !gap_en || ($urandom_range(0, 3) != 0);
            end
            if (tx_q[x].size() > 0) begin
                {sd[x], ss[x], sl[x]} = tx_q[x][0];
            end else begin
                {sd[x], ss[x], sl[x]} = '0;
            end
        end
        case (rdy_mode)
            1:       m_r = ($urandom_range(0, 1) == 1);
            2:       m_r = !(cyc >= lo_start && cyc < lo_start + lo_len);
            default: m_r = 1'b1;
        endcase
        cyc++;
    endtask

    // Called on the falling edge: compare, then advance the model.
    task automatic monitor();
        logic  er0, er1, emv, push, pop;
        logic [1:0] eg;
        beat_t b;
        er0 = (owner == 0) && (occ < 2);
        er1 = (owner == 1) && (occ < 2);
        emv = (occ > 0);
        eg  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        chk("ctrl", 64'({grant, s_r[0], s_r[1], m_v, cnt0, cnt1}),
            64'({eg, er0, er1, emv, mc[0], mc[1]}));
        if (rdy_mode == 2 && cyc == lo_start + lo_len) begin
            chk("bp_stall", 64'({s_r[0], m_v}), 64'(2'b01));
        end
        if (emv && m_r) begin
            beats_out++;
            if (out_src < 0 && gorder.size() > 0) begin
                out_src = gorder.pop_front();
            end
            if (out_src >= 0 && exp_q[out_src].size() > 0) begin
                b = exp_q[out_src].pop_front();
                chk("beat", 64'({m_d, m_s, m_l}), 64'(b));
                if (b.l) out_src = -1;
            end else begin
                fail("beat_unexpected");
            end
        end
        hs[0] = sv[0] && er0;
        hs[1] = sv[1] && er1;
        push  = hs[0] || hs[1];
        pop   = emv && m_r;
        occ   = occ + int'(push) - int'(pop);
        if (owner < 0) begin
            if (sv[0] && sv[1]) owner = (lastg == 1) ? 0 : 1;
            else if (sv[0])     owner = 0;
            else if (sv[1])     owner = 1;
            if (owner >= 0) begin
                lastg = owner;
                gorder.push_back(owner);
                glog.push_back(owner);
            end
        end else if (hs[owner] && sl[owner]) begin
            mc[owner] = mc[owner] + 1'b1;
            owner = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_idle(int budget);
        int n;
        n = 0;
        while ((tx_q[0].size() > 0 || tx_q[1].size() > 0 ||
                occ > 0 || owner >= 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail("timeout");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int x = 0; x < 2; x++) begin
            sv[x] = 1'b0;
            sd[x] = '0;
            ss[x] = '0;
            sl[x] = 1'b0;
            tx_q[x].delete();
            exp_q[x].delete();
            hs[x] = 1'b0;
            mc[x] = '0;
        end
        m_r = 1'b0;
        gorder.delete();
        glog.delete();
        owner = -1;
        occ = 0;
        lastg = 1;
        out_src = -1;
        beats_out = 0;
        cyc = 0;
        gap_en = 1'b0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 64'({grant, s_r[0], s_r[1], m_v, m_d, m_s, m_l,
                          cnt0, cnt1}), 64'(0));
        rst_n = 1'b1;
    endtask

    vec_t tbl [7];

    initial begin
        // Single 4-beat packet on s00, sink always ready.
        tbl[0] = '{1'b1, 32'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0,
                   1'b0, 32'd0, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 32'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0,
                   1'b0, 32'd0, 1'b0, 4'd0};
        tbl[2] = '{1'b1, 32'd1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0,
                   1'b1, 32'd0, 1'b0, 4'd0};
        tbl[3] = '{1'b1, 32'd2, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0,
                   1'b1, 32'd1, 1'b0, 4'd0};
        tbl[4] = '{1'b1, 32'd3, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0,
                   1'b1, 32'd2, 1'b0, 4'd0};
        tbl[5] = '{1'b0, 32'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0,
                   1'b1, 32'd3, 1'b1, 4'd1};
        tbl[6] = '{1'b0, 32'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0,
                   1'b0, 32'd0, 1'b0, 4'd1};

        lo_start = 0;
        lo_len = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            sv[0] = tbl[i].v0;
            sd[0] = tbl[i].d0;
            ss[0] = 4'hF;
            sl[0] = tbl[i].l0;
            m_r   = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                64'({grant, s_r[0], s_r[1], m_v,
                     m_v ? {m_d, m_s, m_l} : 37'd0, cnt0}),
                64'({tbl[i].g, tbl[i].r0, tbl[i].r1, tbl[i].mv,
                     tbl[i].mv ? {tbl[i].md, 4'hF, tbl[i].ml} : 37'd0,
                     tbl[i].c0}));
            @(posedge clk);
            #1;
        end

        // Both inputs request out of reset: s00 wins, no interleave.
        do_reset();
        add_pkt(0, 4, 0, 1'b0);
        add_pkt(1, 4, 100, 1'b0);
        drive();
        run_idle(200);
        chk("simul_order", 64'(log_code()), 64'(16'h0201));
        chk("simul_cnt", 64'({cnt0, cnt1}), 64'(8'h11));

        // Fairness with both inputs continuously backlogged.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            add_pkt(0, 4, 16 * i, 1'b0);
            add_pkt(1, 4, 1000 + 16 * i, 1'b0);
        end
        drive();
        run_idle(400);
        chk("fair_order", 64'(log_code()), 64'(16'h0855));
        chk("fair_cnt", 64'({cnt0, cnt1}), 64'(8'h44));

        // Backpressure: sink stalls for 6 cycles mid-packet.
        do_reset();
        rdy_mode = 2;
        lo_start = 3;
        lo_len = 6;
        add_pkt(0, 8, 200, 1'b0);
        drive();
        run_idle(200);
        chk("bp_beats", 64'(beats_out), 64'(8));

        // Asynchronous reset after beat 1 of a 4-beat packet.
        do_reset();
        add_pkt(0, 2, 'h40, 1'b0);
        drive();
        run_idle(100);
        add_pkt(0, 4, 'h50, 1'b0);
        drive();
        repeat (3) step();
        chk("pre_rst", 64'({m_v, cnt0}), 64'({1'b1, 4'd1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 64'({m_v, grant, s_r[0], cnt0, cnt1}), 64'(0));
        do_reset();
        add_pkt(0, 4, 'h60, 1'b0);
        drive();
        run_idle(100);
        chk("post_rst", 64'({cnt0, beats_out}), 64'({4'd1, 32'd4}));

        // Counter wrap: 17 one-beat packets on s01.
        do_reset();
        for (int i = 0; i < 17; i++) add_pkt(1, 1, 300 + i, 1'b0);
        drive();
        run_idle(500);
        chk("wrap", 64'({cnt0, cnt1}), 64'(8'h01));

        // Random traffic, gaps and sink stalls.
        do_reset();
        gap_en = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            add_pkt(0, $urandom_range(1, 5), 0, 1'b1);
            add_pkt(1, $urandom_range(1, 5), 0, 1'b1);
        end
        drive();
        run_idle(5000);
        chk("rand_cnt", 64'({cnt0, cnt1}), 64'(8'h88));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
